moonbase_bus_responder: RTL

- Target side of the moonbase 8-bit CPU's multiplexed nibble bus; receives the CPU's 8-bit bus output (io_out).
- Replaces the discrete 7-bit address latch + MWS5101-style SRAM + device glue with one synthesizable block for simulation and FPGA bring-up.
- Generates the CPU's io_in[7:2] return signals: 2-bit device data and 4-bit RAM nibble.
- Holds code/data byte memory (two nibbles per byte) and a small bank of device output registers with synchronized device inputs.

---
 rtl/moonbase_bus_pkg.sv | 17 +
 rtl/moonbase_nibble_ram.sv | 29 ++
 rtl/moonbase_bus_responder.sv | 101 ++++++++++
 3 files changed

// File: rtl/moonbase_bus_pkg.sv
// Shared bus field positions and widths for the moonbase nibble-bus responder.
package moonbase_bus_pkg;
    localparam int STROBE_BIT   = 7;
    localparam int SPACE_BIT    = 6;
    localparam int RAM_WE_N_BIT = 5;
    localparam int DEV_WE_N_BIT = 4;

    localparam int NIBBLE_W = 4;
    localparam int DEV_RD_W = 2;
    localparam int BUS_W    = 8;
    localparam int BYTE_W   = 2 * NIBBLE_W;

    typedef enum logic {
        NIB_LO = 1'b0,
        NIB_HI = 1'b1
    } nib_e;
endpackage

// File: rtl/moonbase_nibble_ram.sv
// Byte-wide array with async nibble read and sync per-nibble write.
// Also used as the CPU bench's code store.
module moonbase_nibble_ram
    import moonbase_bus_pkg::*;
#(
    parameter int    WORD_ADDR_W = 8,
    parameter string INIT_FILE   = ""
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [WORD_ADDR_W-1:0] i_addr,
    input  logic                   i_nib,
    input  logic [NIBBLE_W-1:0]    i_wdata,
    output logic [NIBBLE_W-1:0]    o_rdata
);
    logic [BYTE_W-1:0] r_mem [2**WORD_ADDR_W];
    logic [BYTE_W-1:0] w_word;

    // Contents are deliberately left unreset so preloaded code survives CPU resets.
    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_nib) r_mem[i_addr][BYTE_W-1:NIBBLE_W] <= i_wdata;
            else       r_mem[i_addr][NIBBLE_W-1:0]      <= i_wdata;
        end
    end

    assign w_word  = r_mem[i_addr];
    assign o_rdata = i_nib ? w_word[BYTE_W-1:NIBBLE_W] : w_word[NIBBLE_W-1:0];
endmodule

// File: rtl/moonbase_bus_responder.sv
// Target side of the moonbase multiplexed nibble bus: address latch, byte memory,
// device output registers and synchronized device inputs.
module moonbase_bus_responder
    import moonbase_bus_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DEV_IN_W    = 8,
    parameter int DEV_OUT_N   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUS_W-1:0]       i_bus_in,
    output logic [NIBBLE_W-1:0]    o_ram_rd,
    output logic [DEV_RD_W-1:0]    o_dev_rd,
    input  logic [DEV_IN_W-1:0]    i_dev_in,
    output logic [DEV_OUT_N*8-1:0] o_dev_out,
    output logic [DEV_OUT_N-1:0]   o_dev_wr_pulse
);
    localparam int IDX_W   = (DEV_OUT_N > 1) ? $clog2(DEV_OUT_N) : 1;
    localparam int GROUPS  = DEV_IN_W / DEV_RD_W;
    localparam int SEL_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    logic [ADDR_W-1:0]   r_latch;
    nib_e                r_nib;
    logic [BYTE_W-1:0]   r_dev_out [DEV_OUT_N];
    logic [DEV_OUT_N-1:0] r_pulse;
    logic [DEV_IN_W-1:0] r_sync [SYNC_STAGES];

    logic                w_strobe;
    logic                w_ram_we;
    logic                w_dev_we;
    logic [IDX_W-1:0]    w_dev_idx;
    logic [SEL_W-1:0]    w_dev_sel;
    logic                w_dev_hit;
    logic [DEV_IN_W-1:0] w_dev_sync;

    assign w_strobe  = i_bus_in[STROBE_BIT];
    assign w_ram_we  = !w_strobe && !i_bus_in[RAM_WE_N_BIT] && !reset;
    assign w_dev_we  = !w_strobe && !i_bus_in[DEV_WE_N_BIT];
    assign w_dev_idx = IDX_W'(r_latch % ADDR_W'(DEV_OUT_N));
    assign w_dev_sel = r_latch[SEL_W-1:0];
    assign w_dev_hit = (r_latch >> SEL_W) == '0;
    assign w_dev_sync = r_sync[SYNC_STAGES-1];

    moonbase_nibble_ram #(
        .WORD_ADDR_W (ADDR_W + 1),
        .INIT_FILE   ("")
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  ({i_bus_in[SPACE_BIT], r_latch}),
        .i_nib   (r_nib == NIB_HI),
        .i_wdata (i_bus_in[NIBBLE_W-1:0]),
        .o_rdata (o_ram_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch <= '0;
            r_nib   <= NIB_LO;
            r_pulse <= '0;
            for (int i = 0; i < DEV_OUT_N; i++) r_dev_out[i] <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_dev_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_pulse <= '0;
            if (w_strobe) begin
                r_latch <= i_bus_in[ADDR_W-1:0];
                r_nib   <= NIB_LO;
            end else begin
                r_nib <= (r_nib == NIB_LO) ? NIB_HI : NIB_LO;
            end
            // Pulse follows the high-nibble write so the device sees a complete byte.
            if (w_dev_we) begin
                if (r_nib == NIB_HI) begin
                    r_dev_out[w_dev_idx][BYTE_W-1:NIBBLE_W] <= i_bus_in[NIBBLE_W-1:0];
                    r_pulse[w_dev_idx] <= 1'b1;
                end else begin
                    r_dev_out[w_dev_idx][NIBBLE_W-1:0] <= i_bus_in[NIBBLE_W-1:0];
                end
            end
        end
    end

    always_comb begin
        o_dev_rd = '0;
        for (int i = 0; i < GROUPS; i++) begin
            if (w_dev_hit && (w_dev_sel == SEL_W'(i)))
                o_dev_rd = w_dev_sync[i*DEV_RD_W +: DEV_RD_W];
        end
    end

    always_comb begin
        o_dev_out = '0;
        for (int i = 0; i < DEV_OUT_N; i++) o_dev_out[i*8 +: 8] = r_dev_out[i];
    end

    assign o_dev_wr_pulse = r_pulse;
endmodule
